// File: rtl/tlb_pkg.sv
// Shared types and constants for the 4-entry TLB replacement controller.
package tlb_pkg;

   localparam int TLB_ENTRIES = 4;
   localparam int CNT_W       = 12;

   localparam logic [CNT_W-1:0] CNT_MAX = 12'hFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEL   = 2'd1,
      WRITE = 2'd2,
      FLUSH = 2'd3
   } tlb_state_t;

   localparam logic [TLB_ENTRIES-1:0] OH_E0 = 4'b0001;
   localparam logic [TLB_ENTRIES-1:0] OH_E1 = 4'b0010;
   localparam logic [TLB_ENTRIES-1:0] OH_E2 = 4'b0100;
   localparam logic [TLB_ENTRIES-1:0] OH_E3 = 4'b1000;

   function automatic logic [TLB_ENTRIES-1:0] idx_to_oh(input logic [1:0] idx);
      logic [TLB_ENTRIES-1:0] oh;
      case (idx)
         2'd0:    oh = OH_E0;
         2'd1:    oh = OH_E1;
         2'd2:    oh = OH_E2;
         2'd3:    oh = OH_E3;
         default: oh = OH_E0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/tlb_repl_ctrl_victim_pick.sv
// Combinational victim picker: invalid first, then non-G, then lowest counter,
// ties to the lower index. Two-level pairwise compare tree, always one-hot.
module tlb_victim_pick
   import tlb_pkg::*;
(
   input  logic [TLB_ENTRIES-1:0]       valid,
   input  logic [TLB_ENTRIES-1:0]       g,
   input  logic [TLB_ENTRIES*CNT_W-1:0] cnt,
   output logic [TLB_ENTRIES-1:0]       victim
);

   // Rank key, smaller is better. Invalid entries all rank 0 so the index tie-break picks the lowest.
   function automatic logic [CNT_W+1:0] rank_key(input logic v, input logic gb,
                                                 input logic [CNT_W-1:0] c);
      logic [CNT_W+1:0] k;
      if (v) begin
         k = {1'b1, gb, c};
      end else begin
         k = {(CNT_W+2){1'b0}};
      end
      return k;
   endfunction

   logic [CNT_W+1:0] key_s [TLB_ENTRIES];
   logic [CNT_W+1:0] lo_key_s;
   logic [CNT_W+1:0] hi_key_s;
   logic             lo_pick_s;
   logic             hi_pick_s;
   logic             top_pick_s;
   logic [1:0]       win_idx_s;

   // Pairwise tree: strict less-than keeps ties on the lower index at each level.
   always_comb begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         key_s[i] = rank_key(valid[i], g[i], cnt[i*CNT_W +: CNT_W]);
      end
      lo_pick_s = (key_s[1] < key_s[0]);
      hi_pick_s = (key_s[3] < key_s[2]);
      if (lo_pick_s) begin
         lo_key_s = key_s[1];
      end else begin
         lo_key_s = key_s[0];
      end
      if (hi_pick_s) begin
         hi_key_s = key_s[3];
      end else begin
         hi_key_s = key_s[2];
      end
      top_pick_s = (hi_key_s < lo_key_s);
      if (top_pick_s) begin
         win_idx_s = {1'b1, hi_pick_s};
      end else begin
         win_idx_s = {1'b0, lo_pick_s};
      end
      victim = idx_to_oh(win_idx_s);
   end

endmodule

// File: rtl/tlb_repl_ctrl.sv
// TLB replacement/maintenance controller: owns valid, G and access counters,
// ages counters periodically, and sequences refills and flushes.
module tlb_repl_ctrl
   import tlb_pkg::*;
#(
   parameter int               AGE_PERIOD = 1024,
   parameter logic [CNT_W-1:0] CNT_INIT   = 12'd1
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       lookup_valid,
   input  logic [TLB_ENTRIES-1:0]     lookup_hit,
   input  logic                       refill_req,
   input  logic                       refill_g,
   output logic                       refill_ack,
   input  logic                       flush_req,
   input  logic                       flush_keep_g,
   output logic                       flush_ack,
   output logic [TLB_ENTRIES-1:0]     entry_we,
   output logic [TLB_ENTRIES-1:0]     entry_valid,
   output logic [TLB_ENTRIES-1:0]     entry_g,
   output logic [TLB_ENTRIES*CNT_W-1:0] acc_count,
   output logic                       busy
);

   localparam int AGE_W = $clog2(AGE_PERIOD);

   tlb_state_t             state_r;
   logic [TLB_ENTRIES-1:0] victim_r;
   logic                   refill_g_r;
   logic                   keep_g_r;
   logic [TLB_ENTRIES-1:0] valid_r;
   logic [TLB_ENTRIES-1:0] g_r;
   logic [CNT_W-1:0]       cnt_r [TLB_ENTRIES];
   logic [AGE_W-1:0]       age_r;

   logic [TLB_ENTRIES-1:0] victim_s;
   logic [TLB_ENTRIES-1:0] flush_mask_s;
   logic [TLB_ENTRIES-1:0] valid_nxt_s;
   logic [TLB_ENTRIES-1:0] g_nxt_s;
   logic [CNT_W-1:0]       cnt_nxt_s [TLB_ENTRIES];
   logic [CNT_W-1:0]       base_s    [TLB_ENTRIES];
   logic [TLB_ENTRIES-1:0] hit_s;
   logic                   tick_s;

   assign acc_count   = {cnt_r[3], cnt_r[2], cnt_r[1], cnt_r[0]};
   assign entry_valid = valid_r;
   assign entry_g     = g_r;
   assign tick_s      = (age_r == AGE_W'(AGE_PERIOD - 1));

   tlb_victim_pick u_pick (
      .valid  (valid_r),
      .g      (g_r),
      .cnt    (acc_count),
      .victim (victim_s)
   );

   // Next entry state: aging and hits first, then WRITE/FLUSH override them.
   always_comb begin
      if (keep_g_r) begin
         flush_mask_s = ~g_r;
      end else begin
         flush_mask_s = 4'b1111;
      end
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         hit_s[i] = lookup_valid & lookup_hit[i] & valid_r[i];
         if (tick_s) begin
            base_s[i] = {1'b0, cnt_r[i][CNT_W-1:1]};
         end else begin
            base_s[i] = cnt_r[i];
         end
         if (hit_s[i] && (base_s[i] != CNT_MAX)) begin
            cnt_nxt_s[i] = base_s[i] + 12'd1;
         end else begin
            cnt_nxt_s[i] = base_s[i];
         end
         valid_nxt_s[i] = valid_r[i];
         g_nxt_s[i]     = g_r[i];
         if ((state_r == WRITE) && victim_r[i]) begin
            valid_nxt_s[i] = 1'b1;
            g_nxt_s[i]     = refill_g_r;
            cnt_nxt_s[i]   = CNT_INIT;
         end else if ((state_r == FLUSH) && flush_mask_s[i]) begin
            valid_nxt_s[i] = 1'b0;
            cnt_nxt_s[i]   = 12'd0;
         end else begin
            valid_nxt_s[i] = valid_r[i];
         end
      end
   end

   // Entry array state and free-running age timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 4'b0000;
         g_r     <= 4'b0000;
         age_r   <= '0;
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            cnt_r[i] <= 12'd0;
         end
      end else begin
         valid_r <= valid_nxt_s;
         g_r     <= g_nxt_s;
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
         if (tick_s) begin
            age_r <= '0;
         end else begin
            age_r <= age_r + AGE_W'(1);
         end
      end
   end

   // Control FSM; strobes are loaded on the edge entering WRITE/FLUSH so they line up with those states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         victim_r   <= 4'b0000;
         refill_g_r <= 1'b0;
         keep_g_r   <= 1'b0;
         entry_we   <= 4'b0000;
         refill_ack <= 1'b0;
         flush_ack  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         entry_we   <= 4'b0000;
         refill_ack <= 1'b0;
         flush_ack  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (flush_req) begin
                  state_r   <= FLUSH;
                  keep_g_r  <= flush_keep_g;
                  flush_ack <= 1'b1;
                  busy      <= 1'b1;
               end else if (refill_req) begin
                  state_r <= SEL;
                  busy    <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            SEL: begin
               victim_r   <= victim_s;
               refill_g_r <= refill_g;
               entry_we   <= victim_s;
               refill_ack <= 1'b1;
               state_r    <= WRITE;
               busy       <= 1'b1;
            end
            WRITE: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            FLUSH: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_repl_ctrl.sv
// Directed self-checking bench for tlb_repl_ctrl: a long-period instance for
// refill/flush/victim/saturation checks and a short-period one for aging.
module tb_tlb_repl_ctrl;

   logic        clk;
   logic        rst_n, lookup_valid, refill_req, refill_g, flush_req, flush_keep_g;
   logic [3:0]  lookup_hit;
   logic        refill_ack, flush_ack, busy;
   logic [3:0]  entry_we, entry_valid, entry_g;
   logic [47:0] acc_count;

   logic        a_rst_n, a_lookup_valid, a_refill_req, a_refill_g, a_flush_req, a_flush_keep_g;
   logic [3:0]  a_lookup_hit;
   logic        a_refill_ack, a_flush_ack, a_busy;
   logic [3:0]  a_entry_we, a_entry_valid, a_entry_g;
   logic [47:0] a_acc_count;

   int n_cmp = 0;
   int n_err = 0;

   tlb_repl_ctrl #(.AGE_PERIOD(8192), .CNT_INIT(12'd1)) dut (
      .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
      .refill_req(refill_req), .refill_g(refill_g), .refill_ack(refill_ack),
      .flush_req(flush_req), .flush_keep_g(flush_keep_g), .flush_ack(flush_ack),
      .entry_we(entry_we), .entry_valid(entry_valid), .entry_g(entry_g),
      .acc_count(acc_count), .busy(busy)
   );

   tlb_repl_ctrl #(.AGE_PERIOD(8), .CNT_INIT(12'd1)) dut_age (
      .clk(clk), .rst_n(a_rst_n), .lookup_valid(a_lookup_valid), .lookup_hit(a_lookup_hit),
      .refill_req(a_refill_req), .refill_g(a_refill_g), .refill_ack(a_refill_ack),
      .flush_req(a_flush_req), .flush_keep_g(a_flush_keep_g), .flush_ack(a_flush_ack),
      .entry_we(a_entry_we), .entry_valid(a_entry_valid), .entry_g(a_entry_g),
      .acc_count(a_acc_count), .busy(a_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; lookup_valid = 1'b0; lookup_hit = 4'b0000;
      refill_req = 1'b0; refill_g = 1'b0; flush_req = 1'b0; flush_keep_g = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_refill(input logic g, input logic [3:0] exp_we, input string tag);
      int n;
      n = 0;
      refill_req = 1'b1;
      refill_g   = g;
      while (refill_ack !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk_eq({tag, "_lat"}, 48'(n), 48'd2);
      chk_eq({tag, "_we"}, 48'(entry_we), 48'(exp_we));
      refill_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_flush(input logic keep, input string tag);
      int n;
      n = 0;
      flush_req    = 1'b1;
      flush_keep_g = keep;
      while (flush_ack !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk_eq({tag, "_lat"}, 48'(n), 48'd1);
      flush_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_hits(input logic [3:0] mask, input int cycles);
      lookup_valid = 1'b1;
      lookup_hit   = mask;
      repeat (cycles) @(negedge clk);
      lookup_valid = 1'b0;
      lookup_hit   = 4'b0000;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      a_rst_n = 1'b0; a_lookup_valid = 1'b0; a_lookup_hit = 4'b0000;
      a_refill_req = 1'b0; a_refill_g = 1'b0; a_flush_req = 1'b0; a_flush_keep_g = 1'b0;

      // Reset state, then in-order fill of an empty array
      do_reset();
      chk_eq("rst_valid", 48'(entry_valid), 48'h0);
      chk_eq("rst_g", 48'(entry_g), 48'h0);
      chk_eq("rst_cnt", acc_count, 48'h0);
      chk_eq("rst_ctl", 48'({busy, refill_ack, flush_ack, entry_we}), 48'h0);
      do_refill(1'b0, 4'b0001, "fill0");
      do_refill(1'b0, 4'b0010, "fill1");
      do_refill(1'b0, 4'b0100, "fill2");
      do_refill(1'b0, 4'b1000, "fill3");
      chk_eq("fill_valid", 48'(entry_valid), 48'hF);
      chk_eq("fill_cnt", acc_count, 48'h001_001_001_001);

      // Minimum counter with lower-index tie-break
      do_hits(4'b0001, 4);
      do_hits(4'b0010, 2);
      do_hits(4'b0100, 2);
      do_hits(4'b1000, 8);
      chk_eq("hit_cnt", acc_count, 48'h009_003_003_005);
      do_refill(1'b0, 4'b0010, "min_tie");
      chk_eq("min_tie_cnt", acc_count, 48'h009_003_001_005);

      // Non-G entry preferred over lower-count G entries
      do_reset();
      do_refill(1'b1, 4'b0001, "gf0");
      do_refill(1'b1, 4'b0010, "gf1");
      do_refill(1'b1, 4'b0100, "gf2");
      do_refill(1'b0, 4'b1000, "gf3");
      do_hits(4'b1000, 799);
      chk_eq("g_cnt", acc_count, 48'h320_001_001_001);
      do_refill(1'b0, 4'b1000, "nong");
      chk_eq("nong_cnt", acc_count, 48'h001_001_001_001);
      chk_eq("nong_g", 48'(entry_g), 48'h7);

      // Flush keeping G entries, then flush all; hits during FLUSH lose to the flush
      do_reset();
      do_refill(1'b1, 4'b0001, "ff0");
      do_refill(1'b0, 4'b0010, "ff1");
      do_refill(1'b1, 4'b0100, "ff2");
      do_refill(1'b0, 4'b1000, "ff3");
      chk_eq("ff_g", 48'(entry_g), 48'h5);
      lookup_valid = 1'b1; lookup_hit = 4'b0010;
      do_flush(1'b1, "fl_keep");
      lookup_valid = 1'b0; lookup_hit = 4'b0000;
      chk_eq("fl_keep_valid", 48'(entry_valid), 48'h5);
      chk_eq("fl_keep_cnt", acc_count, 48'h000_001_000_001);
      lookup_valid = 1'b1; lookup_hit = 4'b0001;
      do_flush(1'b0, "fl_all");
      lookup_valid = 1'b0; lookup_hit = 4'b0000;
      chk_eq("fl_all_valid", 48'(entry_valid), 48'h0);
      chk_eq("fl_all_cnt", acc_count, 48'h0);
      do_hits(4'b1111, 3);
      chk_eq("hit_invalid", acc_count, 48'h0);

      // Saturation at 12'hFFF
      do_reset();
      do_refill(1'b0, 4'b0001, "sat_fill");
      do_hits(4'b0001, 4094);
      chk_eq("sat_reach", acc_count, 48'h000_000_000_FFF);
      do_hits(4'b0001, 5);
      chk_eq("sat_hold", acc_count, 48'h000_000_000_FFF);

      // Flush wins over refill when both arrive together, refill follows
      do_reset();
      refill_req = 1'b1; refill_g = 1'b1; flush_req = 1'b1; flush_keep_g = 1'b0;
      @(negedge clk);
      chk_eq("both_first", 48'({flush_ack, refill_ack, busy}), 48'b101);
      flush_req = 1'b0;
      n = 0;
      while (refill_ack !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk_eq("both_refill_lat", 48'(n), 48'd3);
      chk_eq("both_we", 48'(entry_we), 48'h1);
      refill_req = 1'b0;
      @(negedge clk);
      chk_eq("both_state", 48'({entry_valid, entry_g}), 48'h11);

      // Reset asserted during SEL drops the refill
      refill_req = 1'b1; refill_g = 1'b0;
      @(negedge clk);
      chk_eq("sel_busy", 48'(busy), 48'h1);
      rst_n = 1'b0;
      #1;
      chk_eq("rst_sel_ctl", 48'({busy, refill_ack, entry_we}), 48'h0);
      chk_eq("rst_sel_state", {entry_valid, entry_g, acc_count[39:0]}, 48'h0);
      refill_req = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("rst_sel_hold", 48'({refill_ack, entry_we}), 48'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("rst_sel_idle", 48'({busy, entry_valid}), 48'h0);

      // Aging with an 8-cycle period: tick lands on every 8th edge after reset release
      a_rst_n = 1'b1;
      a_refill_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_eq("age_ack", 48'({a_refill_ack, a_entry_we}), 48'h11);
      a_refill_req = 1'b0;
      @(negedge clk);
      chk_eq("age_init", a_acc_count, 48'h1);
      a_lookup_valid = 1'b1; a_lookup_hit = 4'b0001;
      repeat (12) @(negedge clk);
      chk_eq("age_pre", a_acc_count, 48'd10);
      @(negedge clk);
      chk_eq("age_tick_hit", a_acc_count, 48'd6);
      a_lookup_valid = 1'b0; a_lookup_hit = 4'b0000;
      repeat (8) @(negedge clk);
      chk_eq("age_tick", a_acc_count, 48'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
